rtc_bcdcounter: RTL and testbench
=================================

RTC_BCDCOUNTER -- requirements
Module: rtc_bcdcounter

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clock cycles per hundredth-second tick (100 MHz -> 100 Hz); legal range 2..2^24.
REQ-002 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset: synchronous, active-high.
REQ-004 i_startstop  input  1  single-cycle pulse; toggles run/stop.
REQ-005 i_lap  input  1  single-cycle pulse; freezes or releases the displayed value while counting continues.
REQ-006 i_clear  input  1  single-cycle pulse; zeroes a paused count.
REQ-007 o_count  output  24  packed BCD value for the display driver, i_count format: [23:20] minute tens, [19:16] minute ones, [15:12] second tens, [11:8] second ones, [7:4] hundredths tens, [3:0] hundredths ones.
REQ-008 o_running  output  1  high in RUN and LAP.
REQ-009 o_lapped  output  1  high in LAP.
REQ-010 o_wrap  output  1  one-cycle pulse on rollover 59:59.99 -> 00:00.00.

Function
REQ-011 States: IDLE (stopped, count zero), RUN, PAUSE (stopped, count nonzero or held), LAP (counting, display frozen).
REQ-012 Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP and wraps to 0; the tick is the cycle it holds TICK_DIV-1; it holds in IDLE/PAUSE and clears on entry to IDLE.
REQ-013 Live count increments by one hundredth on each tick edge; no increment in IDLE/PAUSE.
REQ-014 Digit limits: hundredths ones 0-9, hundredths tens 0-9, second ones 0-9, second tens 0-5, minute ones 0-9, minute tens 0-5; each carries into the next digit on wrap; no digit ever holds an illegal value.
REQ-015 Rollover from 59:59.99 yields 00:00.00; o_wrap is high the cycle after that edge, for exactly one cycle; the state is unchanged.
REQ-016 Transitions: IDLE+startstop->RUN; RUN+startstop->PAUSE; PAUSE+startstop->RUN, resuming from the held count and prescaler value; PAUSE+clear->IDLE, zeroing count and prescaler; RUN+lap->LAP; LAP+lap->RUN; LAP+startstop->PAUSE, display unfrozen.
REQ-017 Ignored pulses: lap in IDLE/PAUSE; clear in IDLE/RUN/LAP; any pulse not listed in REQ-016.
REQ-018 Simultaneous pulses: priority startstop > lap > clear; lower-priority pulses in the same cycle are discarded.
REQ-019 State decisions use the state registered before the edge: a tick coincident with RUN->PAUSE still increments, and no tick increments on the IDLE->RUN edge.
REQ-020 Outside LAP, o_count equals the live count register, so the updated value is visible the cycle after the increment edge.
REQ-021 On entry to LAP, the snapshot captures the value written to the live count on that same edge, including a coincident tick; o_count shows the snapshot until LAP exits.
REQ-022 On exit from LAP, o_count shows the live count the following cycle.
REQ-023 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-024 i_rst high at a clock edge forces: state IDLE; live count, snapshot and prescaler to 0; o_count=24'h000000; o_running=0; o_lapped=0; o_wrap=0.
REQ-025 Reset overrides all other inputs in the same cycle, including mid-count and mid-LAP.
REQ-026 i_startstop, i_lap and i_clear are ignored while i_rst is high.

Verification (TICK_DIV=4)
REQ-027 Reset, then startstop pulse, then 40 cycles -> o_count=24'h000010, o_running=1.
REQ-028 Preload to 00:09.99 via ticks, then one more tick -> o_count=24'h001000; from 00:59.99, one tick -> 24'h010000.
REQ-029 Run to 59:59.99, then one tick -> o_count=24'h000000, o_wrap high exactly one cycle, o_running=1.
REQ-030 Lap pulse at count 24'h000012, then 20 cycles -> o_count stays 24'h000012; second lap pulse -> o_count=24'h000017 next cycle.
REQ-031 Startstop and lap in the same cycle while in RUN -> PAUSE, o_lapped=0; then clear -> o_count=24'h000000 and state IDLE; clear while in RUN -> no effect.
REQ-032 Assert i_rst while in LAP with count 24'h012345 -> next cycle o_count=0, o_running=0, o_lapped=0; the first tick after a new startstop arrives TICK_DIV cycles later.

Source files
------------

// File: rtl/rtc_bcdcounter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bcdcounter_if
//  Purpose  : Control/status bundle for the BCD stopwatch counter.
//             master - drives the control pulses and observes the display.
//             slave  - the counter itself.
//  Signals  : i_startstop  run/stop toggle pulse
//             i_lap        freeze/release display pulse
//             i_clear      zero a paused count pulse
//             o_count      packed BCD mm:ss.hh display value
//             o_running    high while counting (RUN or LAP)
//             o_lapped     high while the display is frozen (LAP)
//             o_wrap       one-cycle pulse on 59:59.99 -> 00:00.00
//  Revision : 1.0 - initial release
// ============================================================================
interface rtc_bcdcounter_if;
    logic        i_startstop;
    logic        i_lap;
    logic        i_clear;
    logic [23:0] o_count;
    logic        o_running;
    logic        o_lapped;
    logic        o_wrap;

    modport master (
        output i_startstop,
        output i_lap,
        output i_clear,
        input  o_count,
        input  o_running,
        input  o_lapped,
        input  o_wrap
    );

    modport slave (
        input  i_startstop,
        input  i_lap,
        input  i_clear,
        output o_count,
        output o_running,
        output o_lapped,
        output o_wrap
    );
endinterface
`default_nettype wire

// File: rtl/rtc_bcdcounter.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bcdcounter
//  Purpose  : Stopwatch counting mm:ss.hh in packed BCD with run/stop, lap
//             (frozen display while counting continues) and clear.
//  Ports    : i_clk  - clock, all state changes on the rising edge
//             i_rst  - synchronous active-high reset
//             bus    - rtc_bcdcounter_if.slave control pulses and outputs
//  Params   : TICK_DIV - clock cycles per hundredth-second tick (2..2^24)
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_bcdcounter #(
    parameter int TICK_DIV = 1000000
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    rtc_bcdcounter_if.slave   bus
);

    localparam int              c_PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_TICK_MAX = c_PW'(TICK_DIV - 1);
    // Per-digit maximum, same packing as o_count: 5 9 : 5 9 . 9 9
    localparam logic [23:0]     c_LIMITS   = 24'h595999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_PW-1:0]   r_presc;
    logic [c_PW-1:0]   w_presc_nxt;
    logic [23:0]       r_live;
    logic [23:0]       w_live_nxt;
    logic [23:0]       w_live_inc;
    logic [23:0]       r_disp;
    logic [23:0]       w_disp_nxt;
    logic              r_wrap;
    logic              w_carry;
    logic              w_counting;
    logic              w_tick;
    logic              w_lap_act;
    logic              w_clr_act;
    logic              w_zero;

    // Only the highest-priority pulse of a cycle is considered at all.
    assign w_lap_act  = !bus.i_startstop && bus.i_lap;
    assign w_clr_act  = !bus.i_startstop && !bus.i_lap && bus.i_clear;

    // Decisions use the state held before the edge.
    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == c_TICK_MAX);
    assign w_zero     = (r_state == S_PAUSE) && (w_state_nxt == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_startstop) w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.i_startstop)  w_state_nxt = S_PAUSE;
                else if (w_lap_act)   w_state_nxt = S_LAP;
            end
            S_PAUSE: begin
                if (bus.i_startstop)  w_state_nxt = S_RUN;
                else if (w_clr_act)   w_state_nxt = S_IDLE;
            end
            S_LAP: begin
                if (bus.i_startstop)  w_state_nxt = S_PAUSE;
                else if (w_lap_act)   w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // BCD ripple increment; a digit at (or somehow above) its limit rolls to
    // zero and passes the carry on. Carry out of the top digit is rollover.
    always_comb begin
        w_live_inc = r_live;
        w_carry    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w_carry) begin
                if (r_live[i*4 +: 4] >= c_LIMITS[i*4 +: 4]) begin
                    w_live_inc[i*4 +: 4] = 4'd0;
                end else begin
                    w_live_inc[i*4 +: 4] = r_live[i*4 +: 4] + 4'd1;
                    w_carry              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_presc_nxt = r_presc;
        w_live_nxt  = r_live;
        if (w_zero) begin
            w_presc_nxt = '0;
            w_live_nxt  = '0;
        end else if (w_counting) begin
            w_presc_nxt = (r_presc == c_TICK_MAX) ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
                w_live_nxt = w_live_inc;
            end
        end
    end

    // The display register doubles as the lap snapshot: it tracks the next
    // live value except while LAP persists, where it holds what was captured
    // on the entry edge.
    always_comb begin
        w_disp_nxt = w_live_nxt;
        if ((w_state_nxt == S_LAP) && (r_state == S_LAP)) begin
            w_disp_nxt = r_disp;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_live  <= '0;
            r_disp  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_live  <= w_live_nxt;
            r_disp  <= w_disp_nxt;
            r_wrap  <= w_tick && w_carry;
        end
    end

    assign bus.o_count   = r_disp;
    assign bus.o_running = (r_state == S_RUN) || (r_state == S_LAP);
    assign bus.o_lapped  = (r_state == S_LAP);
    assign bus.o_wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bcdcounter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_bcdcounter
//  Purpose  : Directed self-checking bench for rtc_bcdcounter, TICK_DIV = 4.
//             Inputs change 1 time unit after a rising edge; outputs are
//             sampled at the same offset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bcdcounter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rtc_bcdcounter_if bus ();

    rtc_bcdcounter #(
        .TICK_DIV (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        bus.i_startstop = ss;
        bus.i_lap       = lp;
        bus.i_clear     = cl;
        step(1);
        bus.i_startstop = 1'b0;
        bus.i_lap       = 1'b0;
        bus.i_clear     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.i_startstop = 1'b0;
        bus.i_lap       = 1'b0;
        bus.i_clear     = 1'b0;

        // Reset state
        step(2);
        chk("rst_count",   bus.o_count,          24'h000000);
        chk("rst_running", {23'd0, bus.o_running}, 24'd0);
        chk("rst_lapped",  {23'd0, bus.o_lapped},  24'd0);
        chk("rst_wrap",    {23'd0, bus.o_wrap},    24'd0);
        rst = 1'b0;

        // Start, 40 cycles = 10 ticks
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_running", {23'd0, bus.o_running}, 24'd1);
        chk("start_count0",  bus.o_count, 24'h000000);
        step(40);
        chk("run40_count",   bus.o_count, 24'h000010);
        chk("run40_running", {23'd0, bus.o_running}, 24'd1);

        // Carry chain into seconds and minutes (989 + 1 + 4999 + 1 ticks)
        step(3956);
        chk("pre_0999",   bus.o_count, 24'h000999);
        step(4);
        chk("carry_1000", bus.o_count, 24'h001000);
        step(19996);
        chk("pre_5999",   bus.o_count, 24'h005999);
        step(4);
        chk("carry_10000", bus.o_count, 24'h010000);

        // Rollover: preload the live count just after a tick boundary
        // (prescaler at 0), so the next tick lands 4 edges later.
        force dut.r_live = 24'h595999;
        @(negedge clk);
        release dut.r_live;
        step(3);
        chk("pre_wrap_count", bus.o_count, 24'h595999);
        chk("pre_wrap_flag",  {23'd0, bus.o_wrap}, 24'd0);
        step(1);
        chk("wrap_count",   bus.o_count, 24'h000000);
        chk("wrap_flag",    {23'd0, bus.o_wrap}, 24'd1);
        chk("wrap_running", {23'd0, bus.o_running}, 24'd1);
        step(1);
        chk("wrap_one_cycle", {23'd0, bus.o_wrap}, 24'd0);

        // Reset overrides a simultaneous startstop
        rst = 1'b1;
        bus.i_startstop = 1'b1;
        step(1);
        rst = 1'b0;
        bus.i_startstop = 1'b0;
        chk("rst_ovr_running", {23'd0, bus.o_running}, 24'd0);
        chk("rst_ovr_count",   bus.o_count, 24'h000000);

        // Lap freeze and release
        pulse(1'b1, 1'b0, 1'b0);
        step(48);
        chk("lap_pre", bus.o_count, 24'h000012);
        pulse(1'b0, 1'b1, 1'b0);
        chk("lap_entry_lapped",  {23'd0, bus.o_lapped},  24'd1);
        chk("lap_entry_running", {23'd0, bus.o_running}, 24'd1);
        chk("lap_entry_count",   bus.o_count, 24'h000012);
        step(20);
        chk("lap_frozen", bus.o_count, 24'h000012);
        pulse(1'b0, 1'b1, 1'b0);
        chk("lap_exit_count",  bus.o_count, 24'h000017);
        chk("lap_exit_lapped", {23'd0, bus.o_lapped}, 24'd0);

        // Clear in RUN is ignored
        pulse(1'b0, 1'b0, 1'b1);
        chk("clr_run_running", {23'd0, bus.o_running}, 24'd1);
        chk("clr_run_count",   bus.o_count, 24'h000017);

        // startstop+lap together: PAUSE; the coincident tick still counts
        pulse(1'b1, 1'b1, 1'b0);
        chk("sslap_running", {23'd0, bus.o_running}, 24'd0);
        chk("sslap_lapped",  {23'd0, bus.o_lapped},  24'd0);
        chk("sslap_count",   bus.o_count, 24'h000018);
        step(8);
        chk("pause_hold", bus.o_count, 24'h000018);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pause_lap_ign_lapped", {23'd0, bus.o_lapped}, 24'd0);
        chk("pause_lap_ign_count",  bus.o_count, 24'h000018);

        // Resume keeps held count and prescaler
        pulse(1'b1, 1'b0, 1'b0);
        chk("resume_running", {23'd0, bus.o_running}, 24'd1);
        step(3);
        chk("resume_no_tick", bus.o_count, 24'h000018);
        step(1);
        chk("resume_tick", bus.o_count, 24'h000019);

        // Pause then clear -> IDLE with prescaler zeroed
        pulse(1'b1, 1'b0, 1'b0);
        chk("pause2_count", bus.o_count, 24'h000019);
        pulse(1'b0, 1'b0, 1'b1);
        chk("clear_count",   bus.o_count, 24'h000000);
        chk("clear_running", {23'd0, bus.o_running}, 24'd0);
        pulse(1'b1, 1'b0, 1'b0);
        step(3);
        chk("idle_start_no_tick", bus.o_count, 24'h000000);
        step(1);
        chk("idle_start_tick", bus.o_count, 24'h000001);

        // Reset while in LAP at 01:23.45
        force dut.r_live = 24'h012345;
        @(negedge clk);
        release dut.r_live;
        pulse(1'b0, 1'b1, 1'b0);
        chk("lap2_count",  bus.o_count, 24'h012345);
        chk("lap2_lapped", {23'd0, bus.o_lapped}, 24'd1);
        step(8);
        chk("lap2_frozen", bus.o_count, 24'h012345);
        rst = 1'b1;
        bus.i_lap = 1'b1;
        step(1);
        rst = 1'b0;
        bus.i_lap = 1'b0;
        chk("lap_rst_count",   bus.o_count, 24'h000000);
        chk("lap_rst_running", {23'd0, bus.o_running}, 24'd0);
        chk("lap_rst_lapped",  {23'd0, bus.o_lapped},  24'd0);
        pulse(1'b1, 1'b0, 1'b0);
        step(3);
        chk("post_rst_no_tick", bus.o_count, 24'h000000);
        step(1);
        chk("post_rst_tick", bus.o_count, 24'h000001);

        // LAP + startstop -> PAUSE with display showing the live count
        pulse(1'b0, 1'b1, 1'b0);
        step(7);
        chk("lap3_frozen", bus.o_count, 24'h000001);
        pulse(1'b1, 1'b0, 1'b0);
        chk("lap_stop_running", {23'd0, bus.o_running}, 24'd0);
        chk("lap_stop_lapped",  {23'd0, bus.o_lapped},  24'd0);
        chk("lap_stop_count",   bus.o_count, 24'h000003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
